// File: rtl/bcd2bin_seq_if.sv
// rtl/bcd2bin_seq_if.sv - request/response bundle between the digit-entry side and bcd2bin_seq
//
// Purpose: groups the conversion handshake so the requester and the converter
// share one typed connection.
// Parameters: DIGITS (packed BCD digits), BIN_W (unsigned result width).
// Optional feature macro: BCD2BIN_SIGN_EN (adds sign_in, widens bin_out by one bit).
// Signals:
//   start    requester -> converter  request a conversion (taken only when idle)
//   bcd_in   requester -> converter  packed BCD operand, digit 0 in bits [3:0]
//   sign_in  requester -> converter  operand sign, BCD2BIN_SIGN_EN builds only
//   busy     converter -> requester  conversion in progress
//   done     converter -> requester  one-cycle result-valid pulse
//   bin_out  converter -> requester  binary result (two's complement when signed)
//   err      converter -> requester  operand contained a digit above 9
// Modports: master = requester side, slave = converter side.
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
`ifdef BCD2BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
`ifdef BCD2BIN_SIGN_EN
  logic                  sign_in;
`endif
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      bin_out;
  logic                  err;

`ifdef BCD2BIN_SIGN_EN
  modport master (output start, bcd_in, sign_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, sign_in, output busy, done, bin_out, err);
`else
  modport master (output start, bcd_in, input busy, done, bin_out, err);
  modport slave  (input start, bcd_in, output busy, done, bin_out, err);
`endif

endinterface

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble)
//
// Purpose: converts a packed BCD operand to binary, one right shift plus
// per-digit subtract-3 correction per cycle, then reports the result with a
// one-cycle done pulse.
// Parameters: DIGITS (packed BCD digits, default 4), BIN_W (result width, default 14).
// Optional feature macro: BCD2BIN_SIGN_EN (signed result, bin_out is BIN_W+1 bits).
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    bcd2bin_seq_if.slave: start/bcd_in(/sign_in) in, busy/done/bin_out/err out

// One BCD digit correction cell: after a right shift a digit that was 10..19
// halved lands on 8..12 and must lose 3; 0..4 is already right. Other codes
// cannot come from valid input and are flushed to 0.
module cond_sub (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = 4'd0;
    if (din <= 4'd4) begin
      dout = din;
    end else if ((din >= 4'd8) && (din <= 4'd12)) begin
      dout = din - 4'd3;
    end
  end
endmodule

module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic          clk,
  input  logic          reset,
  bcd2bin_seq_if.slave  bus
);
  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
`ifdef BCD2BIN_SIGN_EN
  localparam int OUT_W = BIN_W + 1;
`else
  localparam int OUT_W = BIN_W;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [W-1:0]     bcd_reg;
  logic [W-1:0]     bin_reg;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;     // operand rejected; reported at DONE
`ifdef BCD2BIN_SIGN_EN
  logic             sign_reg;
`endif

  logic             done_r;
  logic             err_r;
  logic [OUT_W-1:0] bin_r;

  logic [W-1:0]     bcd_shifted;
  logic [W-1:0]     bcd_fixed;
  logic [W-1:0]     bin_shifted;
  logic [OUT_W-1:0] result;

  logic             digit_bad;
  logic             load;
  logic             reject;
  logic             do_shift;
  logic             finish;

  // Any digit above 9 makes the operand unconvertible.
  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) begin
        digit_bad = 1'b1;
      end
    end
  end

  // Right shift of {bcd_reg, bin_reg}: bcd LSB drops into the bin MSB.
  assign bcd_shifted = {1'b0, bcd_reg[W-1:1]};
  assign bin_shifted = {bcd_reg[0], bin_reg[W-1:1]};

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    cond_sub u_cond_sub (
      .din  (bcd_shifted[4*d +: 4]),
      .dout (bcd_fixed[4*d +: 4])
    );
  end

  // Final value presented at DONE; a rejected operand always reports 0.
`ifdef BCD2BIN_SIGN_EN
  logic [OUT_W-1:0] mag;
  assign mag = {1'b0, bin_reg[BIN_W-1:0]};
  always_comb begin
    result = mag;
    if (err_flag) begin
      result = '0;
    end else if (sign_reg && (mag != '0)) begin
      result = -mag;
    end
  end
`else
  always_comb begin
    result = bin_reg[BIN_W-1:0];
    if (err_flag) begin
      result = '0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    reject     = 1'b0;
    do_shift   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (digit_bad) begin
            reject     = 1'b1;
            state_next = DONE;
          end else begin
            load       = 1'b1;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_reg  <= '0;
      bin_reg  <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      sign_reg <= 1'b0;
`endif
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      bin_r    <= '0;
    end else begin
      done_r <= 1'b0;
      if (load) begin
        bcd_reg  <= bus.bcd_in;
        bin_reg  <= '0;
        cnt      <= CNT_LAST;
        err_flag <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
        sign_reg <= bus.sign_in;
`endif
      end
      if (reject) begin
        err_flag <= 1'b1;
`ifdef BCD2BIN_SIGN_EN
        sign_reg <= bus.sign_in;
`endif
      end
      if (do_shift) begin
        bcd_reg <= bcd_fixed;
        bin_reg <= bin_shifted;
        cnt     <= cnt - 1'b1;
      end
      if (finish) begin
        done_r <= 1'b1;
        err_r  <= err_flag;
        bin_r  <= result;
      end
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.err     = err_r;
  assign bus.bin_out = bin_r;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed table-driven bench for bcd2bin_seq
module tb_bcd2bin_seq;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int VALID_EDGES = 4 * DIGITS + 2;
  localparam int VALID_BUSY  = 4 * DIGITS + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        sgn;
    logic [31:0] bin;
    logic        err;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  vec_t vecs [0:23];
  int   nvec;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_sign(input logic s);
`ifdef BCD2BIN_SIGN_EN
    bus.sign_in = s;
`else
    if (s) $display("note: sign ignored in unsigned build");
`endif
  endtask

  // Called at a falling edge with the DUT idle.
  task automatic run_conv(input logic [15:0] bcd, input logic sgn,
                          input logic [31:0] exp_bin, input logic exp_err, input string nm);
    int edges;
    int busy_n;
    logic [31:0] held;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    set_sign(sgn);
    @(negedge clk);
    edges = 1;
    busy_n = bus.busy ? 1 : 0;
    bus.start  = 1'b0;
    bus.bcd_in = 16'hFFFF;
    set_sign(~sgn);
    while (!bus.done && edges < 100) begin
      @(negedge clk);
      edges++;
      if (bus.busy) busy_n++;
    end
    check({nm, " latency"}, 32'(edges), exp_err ? 32'd2 : 32'(VALID_EDGES));
    check({nm, " busy_cycles"}, 32'(busy_n), exp_err ? 32'd1 : 32'(VALID_BUSY));
    check({nm, " bin_out"}, 32'(bus.bin_out), exp_bin);
    check({nm, " err"}, 32'(bus.err), 32'(exp_err));
    held = 32'(bus.bin_out);
    @(negedge clk);
    check({nm, " done_width"}, 32'(bus.done), 32'd0);
    check({nm, " bin_hold"}, 32'(bus.bin_out), exp_bin);
    if (held !== exp_bin) $display("note: %s result not stable", nm);
  endtask

  initial begin
    int edges;
    int done_cnt;
    total = 0;
    bad   = 0;

    nvec = 0;
    vecs[nvec++] = '{16'h0000, 1'b0, 32'h0000, 1'b0};
    vecs[nvec++] = '{16'h9999, 1'b0, 32'h270F, 1'b0};
    vecs[nvec++] = '{16'h1234, 1'b0, 32'h04D2, 1'b0};
    vecs[nvec++] = '{16'h0007, 1'b0, 32'h0007, 1'b0};
    vecs[nvec++] = '{16'h12A4, 1'b0, 32'h0000, 1'b1};
    vecs[nvec++] = '{16'h0005, 1'b0, 32'h0005, 1'b0};
    vecs[nvec++] = '{16'h0042, 1'b0, 32'h002A, 1'b0};
    vecs[nvec++] = '{16'h0010, 1'b0, 32'h000A, 1'b0};
    vecs[nvec++] = '{16'h000F, 1'b0, 32'h0000, 1'b1};
    vecs[nvec++] = '{16'h1000, 1'b0, 32'h03E8, 1'b0};
    vecs[nvec++] = '{16'hF000, 1'b0, 32'h0000, 1'b1};
    vecs[nvec++] = '{16'h0999, 1'b0, 32'h03E7, 1'b0};
    vecs[nvec++] = '{16'h5000, 1'b0, 32'h1388, 1'b0};
    vecs[nvec++] = '{16'h8081, 1'b0, 32'h1F91, 1'b0};
`ifdef BCD2BIN_SIGN_EN
    vecs[nvec++] = '{16'h0042, 1'b1, 32'h7FD6, 1'b0};
    vecs[nvec++] = '{16'h0000, 1'b1, 32'h0000, 1'b0};
    vecs[nvec++] = '{16'h9999, 1'b1, 32'h58F1, 1'b0};
    vecs[nvec++] = '{16'h12A4, 1'b1, 32'h0000, 1'b1};
    vecs[nvec++] = '{16'h0001, 1'b1, 32'h7FFF, 1'b0};
    vecs[nvec++] = '{16'h0042, 1'b0, 32'h002A, 1'b0};
`endif

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    set_sign(1'b0);
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset bin_out", 32'(bus.bin_out), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < nvec; i++) begin
      run_conv(vecs[i].bcd, vecs[i].sgn, vecs[i].bin, vecs[i].err,
               $sformatf("vec%0d_%04h", i, vecs[i].bcd));
    end

    // Start held high: second operand is taken on the first idle cycle after done.
    bus.start  = 1'b1;
    bus.bcd_in = 16'h1234;
    set_sign(1'b0);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!bus.done && edges < 100);
    check("held first latency", 32'(edges), 32'(VALID_EDGES));
    check("held first bin_out", 32'(bus.bin_out), 32'h04D2);
    bus.bcd_in = 16'h0007;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
      if (edges == 1) bus.start = 1'b0;
    end while (!bus.done && edges < 100);
    check("held retrigger latency", 32'(edges), 32'(VALID_EDGES));
    check("held retrigger bin_out", 32'(bus.bin_out), 32'h0007);
    @(negedge clk);

    // Reset in the middle of a conversion, with an ignored start in between.
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0042;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h9999;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort bin_out", 32'(bus.bin_out), 32'd0);
    check("abort err", 32'(bus.err), 32'd0);
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    run_conv(16'h0042, 1'b0, 32'h002A, 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
